// File: rtl/btb_pkg.sv
// Shared types for the BTB update scheduler.
//   PC_W        : default PC / target width (BTB has 2**PC_W entries)
//   BTB_ENTRIES : BTB entry count
//   btb_upd_t   : one queued update record {taken, target, pc}
//   btb_state_e : scheduler FSM state
package btb_pkg;

  localparam int unsigned PC_W        = 4;
  localparam int unsigned BTB_ENTRIES = 2 ** PC_W;

  typedef struct packed {
    logic            taken;
    logic [PC_W-1:0] target;
    logic [PC_W-1:0] pc;
  } btb_upd_t;

  typedef enum logic [0:0] {
    StNormal = 1'b0,
    StFlush  = 1'b1
  } btb_state_e;

endpackage

// File: rtl/btb_update_fifo.sv
// In-order update queue with ordered dual push (A ahead of B), single pop and clear.
//   i_clk, i_reset_n     : clock, async active-low reset
//   i_clear              : drop all contents (wins over push/pop)
//   i_push_a, i_data_a   : first push slot
//   i_push_b, i_data_b   : second push slot, lands behind A when both push
//   i_pop                : consume head (ignored when empty)
//   o_head, o_empty      : head entry and empty flag
//   o_count              : occupancy, 0..Depth
// Caller guarantees pushes never exceed free space plus the slot freed by a same-cycle pop.
module btb_update_fifo #(
  parameter int unsigned Width = 9,
  parameter int unsigned Depth = 4
) (
  input  logic                     i_clk,
  input  logic                     i_reset_n,
  input  logic                     i_clear,
  input  logic                     i_push_a,
  input  logic [Width-1:0]         i_data_a,
  input  logic                     i_push_b,
  input  logic [Width-1:0]         i_data_b,
  input  logic                     i_pop,
  output logic [Width-1:0]         o_head,
  output logic                     o_empty,
  output logic [$clog2(Depth):0]   o_count
);

  localparam int unsigned AW = $clog2(Depth);
  localparam int unsigned CW = AW + 1;

  logic [Width-1:0] r_mem [Depth];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  logic [AW-1:0]    w_wr_ptr1;
  logic [CW-1:0]    w_n_push;
  logic             w_pop;

  assign w_wr_ptr1 = r_wr_ptr + AW'(1);
  assign w_n_push  = CW'(i_push_a) + CW'(i_push_b);
  assign w_pop     = i_pop & ~o_empty;

  // Storage needs no reset; occupancy tracking makes stale slots invisible.
  always_ff @(posedge i_clk) begin
    if (!i_clear) begin
      if (i_push_a) r_mem[r_wr_ptr] <= i_data_a;
      if (i_push_b) r_mem[i_push_a ? w_wr_ptr1 : r_wr_ptr] <= i_data_b;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + AW'(w_n_push);
      r_rd_ptr <= r_rd_ptr + AW'(w_pop);
      r_count  <= r_count + w_n_push - CW'(w_pop);
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule

// File: rtl/btb_update_scheduler.sv
// Funnels branch-resolution updates from port A (branch ALU) and port B (jump unit)
// onto the single BTB write port, and sequences a full-table invalidate sweep.
//   i_clk, i_reset_n                      : clock, async active-low reset
//   i_a_* / o_a_ready                     : port A update handshake and payload
//   i_b_* / o_b_ready                     : port B update handshake and payload
//   i_flush_req                           : one-cycle request to invalidate the whole BTB
//   o_flush_busy, o_flush_done            : sweep in progress / one-cycle completion pulse
//   o_btb_wr_valid/_pc/_target/_taken     : BTB write port
//   o_upd_count                           : saturating count of A/B writes (sweeps excluded)
// PC_W must match btb_pkg::PC_W, which sizes the queued record type.
module btb_update_scheduler
  import btb_pkg::*;
#(
  parameter int unsigned PC_W       = btb_pkg::PC_W,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_a_valid,
  output logic             o_a_ready,
  input  logic [PC_W-1:0]  i_a_pc,
  input  logic [PC_W-1:0]  i_a_target,
  input  logic             i_a_taken,
  input  logic             i_b_valid,
  output logic             o_b_ready,
  input  logic [PC_W-1:0]  i_b_pc,
  input  logic [PC_W-1:0]  i_b_target,
  input  logic             i_b_taken,
  input  logic             i_flush_req,
  output logic             o_flush_busy,
  output logic             o_flush_done,
  output logic             o_btb_wr_valid,
  output logic [PC_W-1:0]  o_btb_wr_pc,
  output logic [PC_W-1:0]  o_btb_wr_target,
  output logic             o_btb_wr_taken,
  output logic [CNT_W-1:0] o_upd_count
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned RW = CW + 1;
  localparam logic [RW-1:0]    DepthR    = RW'(FIFO_DEPTH);
  localparam logic [PC_W-1:0]  SweepLast = {PC_W{1'b1}};
  localparam logic [CNT_W-1:0] CntMax    = {CNT_W{1'b1}};

  btb_state_e       r_state;
  btb_state_e       w_state_d;
  logic             r_active;
  logic [PC_W-1:0]  r_sweep;
  logic             r_flush_done;
  logic [CNT_W-1:0] r_upd_count;

  btb_upd_t         w_a_rec;
  btb_upd_t         w_b_rec;
  btb_upd_t         w_head;
  logic             w_empty;
  logic [CW-1:0]    w_count;
  logic [RW-1:0]    w_room;
  logic             w_normal;
  logic             w_flush_start;
  logic             w_push_a;
  logic             w_push_b;
  logic             w_norm_wr;

  assign w_normal = (r_state == StNormal);

  // The head pops in the same cycle as any push, so a full queue still has one slot.
  assign w_room = DepthR - RW'(w_count) + RW'(w_count != '0);

  // r_active keeps ready low from reset until the first clock after release.
  assign o_a_ready = r_active & w_normal & (w_room >= RW'(1));
  assign o_b_ready = r_active & w_normal & (w_room >= RW'(2));

  assign w_flush_start = w_normal & i_flush_req;

  // A transfer completing on the flush edge is stale and is dropped.
  assign w_push_a = i_a_valid & o_a_ready & ~w_flush_start;
  assign w_push_b = i_b_valid & o_b_ready & ~w_flush_start;

  // The head is suppressed on the flush edge so nothing queued reaches the BTB.
  assign w_norm_wr = w_normal & ~w_empty & ~i_flush_req;

  assign w_a_rec = '{taken: i_a_taken, target: i_a_target, pc: i_a_pc};
  assign w_b_rec = '{taken: i_b_taken, target: i_b_target, pc: i_b_pc};

  btb_update_fifo #(
    .Width ($bits(btb_upd_t)),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_clear   (w_flush_start),
    .i_push_a  (w_push_a),
    .i_data_a  (w_a_rec),
    .i_push_b  (w_push_b),
    .i_data_b  (w_b_rec),
    .i_pop     (w_norm_wr),
    .o_head    (w_head),
    .o_empty   (w_empty),
    .o_count   (w_count)
  );

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StNormal: if (w_flush_start) w_state_d = StFlush;
      StFlush:  if (r_sweep == SweepLast) w_state_d = StNormal;
      default:  w_state_d = StNormal;
    endcase
  end

  always_comb begin
    o_btb_wr_valid  = 1'b0;
    o_btb_wr_pc     = '0;
    o_btb_wr_target = '0;
    o_btb_wr_taken  = 1'b0;
    if (r_state == StFlush) begin
      o_btb_wr_valid = 1'b1;
      o_btb_wr_pc    = r_sweep;
    end else if (w_norm_wr) begin
      o_btb_wr_valid  = 1'b1;
      o_btb_wr_pc     = w_head.pc;
      o_btb_wr_target = w_head.target;
      o_btb_wr_taken  = w_head.taken;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state      <= StNormal;
      r_active     <= 1'b0;
      r_sweep      <= '0;
      r_flush_done <= 1'b0;
      r_upd_count  <= '0;
    end else begin
      r_state      <= w_state_d;
      r_active     <= 1'b1;
      // Wraps to zero after the last index, ready for the next sweep.
      if (r_state == StFlush) r_sweep <= r_sweep + PC_W'(1);
      r_flush_done <= (r_state == StFlush) && (r_sweep == SweepLast);
      if (w_norm_wr && (r_upd_count != CntMax)) r_upd_count <= r_upd_count + CNT_W'(1);
    end
  end

  assign o_flush_busy = (r_state == StFlush);
  assign o_flush_done = r_flush_done;
  assign o_upd_count  = r_upd_count;

endmodule

// File: tb/tb_btb_update_scheduler.sv
// Directed bench for btb_update_scheduler: reset, single and dual updates, back-pressure,
// flush sweeps (plain, re-requested, reset mid-sweep) and counter saturation.
module tb_btb_update_scheduler;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       a_valid, a_taken, b_valid, b_taken, flush_req;
  logic [3:0] a_pc, a_target, b_pc, b_target;
  logic       a_ready, b_ready, flush_busy, flush_done;
  logic       wr_valid, wr_taken;
  logic [3:0] wr_pc, wr_target;
  logic [7:0] upd_count;

  int n_vec  = 0;
  int n_miss = 0;
  int exp_cnt = 0;

  btb_update_scheduler #(
    .PC_W       (4),
    .FIFO_DEPTH (4),
    .CNT_W      (8)
  ) dut (
    .i_clk           (clk),
    .i_reset_n       (reset_n),
    .i_a_valid       (a_valid),
    .o_a_ready       (a_ready),
    .i_a_pc          (a_pc),
    .i_a_target      (a_target),
    .i_a_taken       (a_taken),
    .i_b_valid       (b_valid),
    .o_b_ready       (b_ready),
    .i_b_pc          (b_pc),
    .i_b_target      (b_target),
    .i_b_taken       (b_taken),
    .i_flush_req     (flush_req),
    .o_flush_busy    (flush_busy),
    .o_flush_done    (flush_done),
    .o_btb_wr_valid  (wr_valid),
    .o_btb_wr_pc     (wr_pc),
    .o_btb_wr_target (wr_target),
    .o_btb_wr_taken  (wr_taken),
    .o_upd_count     (upd_count)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish, observed running expected finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One full sweep; the flush request is re-raised at index refl_at (-1 for never).
  task automatic sweep(input int refl_at);
    for (int i = 0; i < 16; i++) begin
      flush_req = (i == refl_at);
      #1;
      check("sweep", 32'({flush_busy, wr_valid, wr_pc, wr_target, wr_taken,
                          a_ready, b_ready, flush_done}),
            32'({1'b1, 1'b1, 4'(i), 4'd0, 1'b0, 3'b000}));
      tick;
    end
    flush_req = 1'b0;
    #1;
    // {done, busy, a_ready, b_ready, wr_valid}
    check("sweep_end", 32'({flush_done, flush_busy, a_ready, b_ready, wr_valid}), 32'b10110);
    check("sweep_cnt", 32'(upd_count), 32'(exp_cnt));
    tick;
    check("done_pulse", 32'(flush_done), 0);
  endtask

  logic [8:0] q[$];
  int  a_id, b_id;
  logic exp_b;

  initial begin
    reset_n = 1'b0;
    a_valid = 0; a_pc = 0; a_target = 0; a_taken = 0;
    b_valid = 0; b_pc = 0; b_target = 0; b_taken = 0;
    flush_req = 0;
    #3;
    check("reset_outs", 32'({a_ready, b_ready, flush_busy, flush_done, wr_valid, wr_pc,
                             wr_target, wr_taken, upd_count}), 0);
    #9 reset_n = 1'b1;
    tick;
    check("ready_after_rst", 32'({a_ready, b_ready}), 32'b11);

    // Single A update.
    a_valid = 1; a_pc = 4'd3; a_target = 4'd9; a_taken = 1;
    #1;
    check("single_pre_wr", 32'(wr_valid), 0);
    tick;
    a_valid = 0;
    #1;
    check("single_wr", 32'({wr_valid, wr_taken, wr_target, wr_pc}), 32'({1'b1, 1'b1, 4'd9, 4'd3}));
    tick;
    check("single_cnt", 32'({wr_valid, upd_count}), 32'({1'b0, 8'd1}));
    exp_cnt = 1;

    // A and B together, same PC.
    a_valid = 1; a_pc = 4'd5; a_target = 4'd2; a_taken = 0;
    b_valid = 1; b_pc = 4'd5; b_target = 4'd7; b_taken = 0;
    #1;
    check("dual_ready", 32'({a_ready, b_ready}), 32'b11);
    tick;
    a_valid = 0; b_valid = 0;
    #1;
    check("dual_wr_a", 32'({wr_valid, wr_taken, wr_target, wr_pc}), 32'({1'b1, 1'b0, 4'd2, 4'd5}));
    tick;
    check("dual_wr_b", 32'({wr_valid, wr_taken, wr_target, wr_pc}), 32'({1'b1, 1'b0, 4'd7, 4'd5}));
    tick;
    check("dual_cnt", 32'({wr_valid, upd_count}), 32'({1'b0, 8'd3}));
    exp_cnt = 3;

    // Sustained A+B traffic against a queue model.
    a_id = 0; b_id = 1;
    for (int c = 0; c < 8; c++) begin
      exp_b = (q.size() < 4);
      a_valid = 1; a_pc = 4'(a_id); a_target = ~4'(a_id); a_taken = 0;
      b_valid = 1; b_pc = 4'(b_id); b_target = 4'(b_id + 3); b_taken = 1;
      #1;
      check("fill_ardy", 32'(a_ready), 1);
      check("fill_brdy", 32'(b_ready), 32'(exp_b));
      if (q.size() > 0) begin
        check("fill_wr", 32'({wr_valid, wr_taken, wr_target, wr_pc}), 32'({1'b1, q[0]}));
        q.delete(0);
        exp_cnt++;
      end else begin
        check("fill_wr_idle", 32'(wr_valid), 0);
      end
      q.push_back({1'b0, ~4'(a_id), 4'(a_id)});
      a_id += 2;
      if (exp_b) begin
        q.push_back({1'b1, 4'(b_id + 3), 4'(b_id)});
        b_id += 2;
      end
      tick;
    end
    a_valid = 0; b_valid = 0;
    for (int c = 0; c < 8 && q.size() > 0; c++) begin
      #1;
      check("drain_wr", 32'({wr_valid, wr_taken, wr_target, wr_pc}), 32'({1'b1, q[0]}));
      q.delete(0);
      exp_cnt++;
      tick;
    end
    check("drain_empty", 32'({wr_valid, upd_count}), 32'({1'b0, 8'(exp_cnt)}));

    // Queue three updates, then flush: none of them reach the BTB.
    a_valid = 1; a_pc = 4'd10; a_target = 4'd1; a_taken = 1;
    b_valid = 1; b_pc = 4'd11; b_target = 4'd2; b_taken = 1;
    tick;
    a_pc = 4'd12; b_pc = 4'd13;
    tick;
    exp_cnt++;
    b_valid = 0; a_pc = 4'd14; flush_req = 1;
    #1;
    check("flush_edge_wr", 32'(wr_valid), 0);
    check("flush_edge_rdy", 32'({a_ready, b_ready, flush_busy}), 32'b110);
    tick;
    a_valid = 0; flush_req = 0;
    sweep(-1);

    // Re-request mid-sweep is ignored.
    flush_req = 1;
    #1;
    check("flush2_idle", 32'({flush_busy, wr_valid}), 0);
    tick;
    sweep(6);

    // Reset in the middle of a sweep.
    flush_req = 1;
    tick;
    flush_req = 0;
    for (int i = 0; i < 9; i++) tick;
    check("sweep_at9", 32'({flush_busy, wr_pc}), 32'({1'b1, 4'd9}));
    reset_n = 0;
    #1;
    check("mid_rst_outs", 32'({a_ready, b_ready, flush_busy, flush_done, wr_valid, wr_pc,
                               wr_target, wr_taken, upd_count}), 0);
    #2 reset_n = 1;
    tick;
    check("post_rst", 32'({a_ready, b_ready, flush_busy, wr_valid, upd_count}),
          32'({4'b1100, 8'd0}));

    // 300 back-to-back A updates saturate the counter.
    a_valid = 1; a_pc = 4'd1; a_target = 4'd4; a_taken = 0;
    for (int i = 0; i < 300; i++) begin
      if (i == 255) check("sat_254", 32'(upd_count), 254);
      if (i == 256) check("sat_255", 32'(upd_count), 255);
      tick;
    end
    a_valid = 0;
    tick;
    check("sat_final", 32'({wr_valid, upd_count}), 32'({1'b0, 8'd255}));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
